// File: rtl/plat_land_scan_pkg.sv
// Shared constants, FSM encoding and platform-table slice helpers for the
// platform landing scanner.
package plat_land_scan_pkg;

  localparam int PLATFORM_NUM_PER_BLOCK = 7;
  localparam int PHY_WIDTH              = 16;
  localparam int BLOCK_LEN_WIDTH        = 4;
  localparam int PLAT_UNIT_SHIFT        = 3;
  localparam int CHAR_WIDTH             = 16;
  localparam int IDX_WIDTH              = 3;

  // Widths of the packed per-block platform tables.
  localparam int PLAT_XY_BUS_W  = PLATFORM_NUM_PER_BLOCK * PHY_WIDTH;
  localparam int PLAT_LEN_BUS_W = PLATFORM_NUM_PER_BLOCK * BLOCK_LEN_WIDTH;

  // Index of the final platform in a scan.
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(PLATFORM_NUM_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  // Pull one x or y coordinate out of a packed platform table.
  function automatic logic [PHY_WIDTH-1:0] plat_coord(
    input logic [PLAT_XY_BUS_W-1:0] bus,
    input logic [IDX_WIDTH-1:0]     idx
  );
    return bus[int'(idx) * PHY_WIDTH +: PHY_WIDTH];
  endfunction

  // Pull one length (in tiles) out of the packed length table.
  function automatic logic [BLOCK_LEN_WIDTH-1:0] plat_len_at(
    input logic [PLAT_LEN_BUS_W-1:0] bus,
    input logic [IDX_WIDTH-1:0]      idx
  );
    return bus[int'(idx) * BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
  endfunction

endpackage

// File: rtl/plat_land_scan_if.sv
// Request/result bundle between the physics stage (master) and the landing
// scanner (slave), including the block generator's platform tables.
interface plat_land_scan_if;
  import plat_land_scan_pkg::*;

  logic                              start;
  logic [PHY_WIDTH-1:0]              char_x;
  logic [PHY_WIDTH:0]                prev_y;
  logic [PHY_WIDTH:0]                next_y;
  logic [PLAT_XY_BUS_W-1:0]          plat_relative_x;
  logic [PLAT_XY_BUS_W-1:0]          plat_relative_y;
  logic [PLAT_LEN_BUS_W-1:0]         plat_len;
  logic                              block_switch;
  logic                              busy;
  logic                              done;
  logic                              landed;
  logic [IDX_WIDTH-1:0]              land_idx;
  logic [PHY_WIDTH:0]                land_y;

  modport master (
    output start, char_x, prev_y, next_y,
    output plat_relative_x, plat_relative_y, plat_len, block_switch,
    input  busy, done, landed, land_idx, land_y
  );

  modport slave (
    input  start, char_x, prev_y, next_y,
    input  plat_relative_x, plat_relative_y, plat_len, block_switch,
    output busy, done, landed, land_idx, land_y
  );

endinterface

// File: rtl/plat_land_scan_plat_hit_check.sv
// Single-platform landing test: does the character's downward sweep cross the
// platform's top surface while horizontally overlapping it?
module plat_hit_check
  import plat_land_scan_pkg::*;
(
  input  logic [PHY_WIDTH-1:0]       px,
  input  logic [PHY_WIDTH-1:0]       py,
  input  logic [BLOCK_LEN_WIDTH-1:0] len,
  input  logic [PHY_WIDTH-1:0]       char_x,
  input  logic [PHY_WIDTH:0]         prev_y,
  input  logic [PHY_WIDTH:0]         next_y,
  output logic                       hit
);

  localparam int CW = PHY_WIDTH + 2;
  localparam int PW = BLOCK_LEN_WIDTH + PLAT_UNIT_SHIFT;

  logic signed [CW-1:0] prev_s;
  logic signed [CW-1:0] next_s;
  logic signed [CW-1:0] py_s;
  logic signed [CW-1:0] px_s;
  logic signed [CW-1:0] char_l_s;
  logic signed [CW-1:0] char_r_s;
  logic signed [CW-1:0] plat_r_s;
  logic [PW-1:0]        pw_s;

  // Widen everything to one signed compare width so no sum can wrap.
  always_comb begin
    pw_s     = {len, {PLAT_UNIT_SHIFT{1'b0}}};
    prev_s   = $signed({prev_y[PHY_WIDTH], prev_y});
    next_s   = $signed({next_y[PHY_WIDTH], next_y});
    py_s     = $signed({2'b00, py});
    px_s     = $signed({2'b00, px});
    char_l_s = $signed({2'b00, char_x});
    char_r_s = char_l_s + $signed(CW'(CHAR_WIDTH));
    plat_r_s = px_s + $signed({{(CW-PW){1'b0}}, pw_s});
    // A zero-length platform has no surface, so it must never be landed on.
    hit = (len != {BLOCK_LEN_WIDTH{1'b0}}) &&
          (next_s < prev_s) &&
          (prev_s >= py_s) &&
          (next_s <= py_s) &&
          (char_r_s > px_s) &&
          (char_l_s < plat_r_s);
  end

endmodule

// File: rtl/plat_land_scan.sv
// Per-tick landing scanner: walks the current block's platforms one per cycle
// and reports the highest platform the character's fall crosses.
module plat_land_scan
  import plat_land_scan_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst,
  plat_land_scan_if.slave   bus
);

  scan_state_e              state_r, state_next_s;
  logic [IDX_WIDTH-1:0]     idx_r, idx_next_s;
  logic                     latch_s;

  logic [PHY_WIDTH-1:0]     char_x_r;
  logic [PHY_WIDTH:0]       prev_y_r;
  logic [PHY_WIDTH:0]       next_y_r;

  logic                     best_valid_r, best_valid_next_s;
  logic [IDX_WIDTH-1:0]     best_idx_r, best_idx_next_s;
  logic [PHY_WIDTH-1:0]     best_py_r, best_py_next_s;

  logic [PHY_WIDTH-1:0]       px_s;
  logic [PHY_WIDTH-1:0]       py_s;
  logic [BLOCK_LEN_WIDTH-1:0] len_s;
  logic                       hit_s;

  logic                     busy_r;
  logic                     done_r;
  logic                     landed_r;
  logic [IDX_WIDTH-1:0]     land_idx_r;
  logic [PHY_WIDTH:0]       land_y_r;

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.landed   = landed_r;
  assign bus.land_idx = land_idx_r;
  assign bus.land_y   = land_y_r;

  // Select the platform under test straight from the live tables.
  always_comb begin
    px_s  = plat_coord(bus.plat_relative_x, idx_r);
    py_s  = plat_coord(bus.plat_relative_y, idx_r);
    len_s = plat_len_at(bus.plat_len, idx_r);
  end

  plat_hit_check u_hit (
    .px     (px_s),
    .py     (py_s),
    .len    (len_s),
    .char_x (char_x_r),
    .prev_y (prev_y_r),
    .next_y (next_y_r),
    .hit    (hit_s)
  );

  // FSM state, scan index and best-hit register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= {IDX_WIDTH{1'b0}};
      best_valid_r <= 1'b0;
      best_idx_r   <= {IDX_WIDTH{1'b0}};
      best_py_r    <= {PHY_WIDTH{1'b0}};
    end else begin
      state_r      <= state_next_s;
      idx_r        <= idx_next_s;
      best_valid_r <= best_valid_next_s;
      best_idx_r   <= best_idx_next_s;
      best_py_r    <= best_py_next_s;
    end
  end

  // Next state, index stepping and highest-platform arbitration.
  always_comb begin
    state_next_s      = state_r;
    idx_next_s        = idx_r;
    latch_s           = 1'b0;
    best_valid_next_s = best_valid_r;
    best_idx_next_s   = best_idx_r;
    best_py_next_s    = best_py_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_next_s      = ST_SCAN;
          idx_next_s        = {IDX_WIDTH{1'b0}};
          latch_s           = 1'b1;
          best_valid_next_s = 1'b0;
          best_idx_next_s   = {IDX_WIDTH{1'b0}};
          best_py_next_s    = {PHY_WIDTH{1'b0}};
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (bus.block_switch) begin
          // New tables: anything found so far belongs to the old block.
          idx_next_s        = {IDX_WIDTH{1'b0}};
          best_valid_next_s = 1'b0;
          best_idx_next_s   = {IDX_WIDTH{1'b0}};
          best_py_next_s    = {PHY_WIDTH{1'b0}};
        end else begin
          // Strict compare keeps the lower index on equal heights.
          if (hit_s && (!best_valid_r || (py_s > best_py_r))) begin
            best_valid_next_s = 1'b1;
            best_idx_next_s   = idx_r;
            best_py_next_s    = py_s;
          end else begin
            best_valid_next_s = best_valid_r;
          end
          if (idx_r == LAST_IDX) begin
            state_next_s = ST_DONE;
            idx_next_s   = {IDX_WIDTH{1'b0}};
          end else begin
            idx_next_s = idx_r + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
          end
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s      = ST_IDLE;
        idx_next_s        = {IDX_WIDTH{1'b0}};
        best_valid_next_s = 1'b0;
        best_idx_next_s   = {IDX_WIDTH{1'b0}};
        best_py_next_s    = {PHY_WIDTH{1'b0}};
      end
    endcase
  end

  // Capture the character's sweep so the tick's inputs may change mid-scan.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      char_x_r <= {PHY_WIDTH{1'b0}};
      prev_y_r <= {(PHY_WIDTH+1){1'b0}};
      next_y_r <= {(PHY_WIDTH+1){1'b0}};
    end else if (latch_s) begin
      char_x_r <= bus.char_x;
      prev_y_r <= bus.prev_y;
      next_y_r <= bus.next_y;
    end
  end

  // Registered status and result; the result is held until the next done.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      landed_r   <= 1'b0;
      land_idx_r <= {IDX_WIDTH{1'b0}};
      land_y_r   <= {(PHY_WIDTH+1){1'b0}};
    end else begin
      busy_r <= (state_next_s == ST_SCAN);
      done_r <= (state_next_s == ST_DONE);
      if ((state_r == ST_SCAN) && (state_next_s == ST_DONE)) begin
        landed_r   <= best_valid_next_s;
        land_idx_r <= best_valid_next_s ? best_idx_next_s : {IDX_WIDTH{1'b0}};
        land_y_r   <= best_valid_next_s ? {1'b0, best_py_next_s} : {(PHY_WIDTH+1){1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_plat_land_scan.sv
// Directed self-checking bench for the platform landing scanner.
module tb_plat_land_scan;
  import plat_land_scan_pkg::*;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   errors  = 0;
  int   checks  = 0;

  plat_land_scan_if bus();

  plat_land_scan dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_tables();
    bus.plat_relative_x = '0;
    bus.plat_relative_y = '0;
    bus.plat_len        = '0;
  endtask

  task automatic set_plat(input int i, input logic [15:0] x, input logic [15:0] y, input logic [3:0] l);
    bus.plat_relative_x[i*16 +: 16] = x;
    bus.plat_relative_y[i*16 +: 16] = y;
    bus.plat_len[i*4 +: 4]          = l;
  endtask

  // Runs a 15-cycle window: start in cycle 0, optional block switch (with new
  // tables), second start and reset at given cycles; snapshot taken at cycle 6.
  task automatic run_scan(
    input  logic [15:0]  cx, input logic [16:0] py0, input logic [16:0] ny0,
    input  int sw_cyc, input int st2_cyc, input int rst_cyc,
    input  logic [111:0] nx, input logic [111:0] ny, input logic [27:0] nl,
    output int done_cyc, output int done_cnt, output logic [15:0] busy_mask,
    output logic o_landed, output logic [2:0] o_idx, output logic [16:0] o_y,
    output logic [22:0] snap
  );
    done_cyc = -1; done_cnt = 0; busy_mask = '0;
    o_landed = 1'b0; o_idx = '0; o_y = '0; snap = '0;
    @(posedge sys_clk); #1;
    bus.char_x = cx; bus.prev_y = py0; bus.next_y = ny0; bus.start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge sys_clk); #1;
      bus.start        = (k == st2_cyc);
      bus.block_switch = (k == sw_cyc);
      if (k == sw_cyc) begin
        bus.plat_relative_x = nx; bus.plat_relative_y = ny; bus.plat_len = nl;
      end
      sys_rst = (k == rst_cyc);
      if (bus.busy) busy_mask[k] = 1'b1;
      if (k == 6) snap = {bus.busy, bus.done, bus.landed, bus.land_idx, bus.land_y};
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = k; o_landed = bus.landed; o_idx = bus.land_idx; o_y = bus.land_y;
        end
      end
    end
    bus.start = 1'b0; bus.block_switch = 1'b0; sys_rst = 1'b0;
  endtask

  initial begin
    int          dc, dn;
    logic [15:0] bm;
    logic        ld;
    logic [2:0]  li;
    logic [16:0] ly;
    logic [22:0] sn;
    logic [111:0] nx, ny;
    logic [27:0]  nl;

    bus.start = 1'b0; bus.block_switch = 1'b0;
    bus.char_x = '0; bus.prev_y = '0; bus.next_y = '0;
    clear_tables();
    nx = '0; ny = '0; nl = '0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;

    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_landed",   32'(bus.landed),   32'd0);
    check("rst_land_idx", 32'(bus.land_idx), 32'd0);
    check("rst_land_y",   32'(bus.land_y),   32'd0);

    // Basic fall onto platform 0 (280..359, top 35).
    set_plat(0, 16'd280, 16'd35, 4'd10);
    run_scan(16'd300, 17'd40, 17'd30, -1, -1, -1, nx, ny, nl, dc, dn, bm, ld, li, ly, sn);
    check("t1_done_cyc",  32'(dc), 32'd8);
    check("t1_done_cnt",  32'(dn), 32'd1);
    check("t1_busy_mask", 32'(bm), 32'h00FE);
    check("t1_landed",    32'(ld), 32'd1);
    check("t1_idx",       32'(li), 32'd0);
    check("t1_y",         32'(ly), 32'd35);

    // Left edge at the platform's right end: no overlap.
    run_scan(16'd360, 17'd40, 17'd30, -1, -1, -1, nx, ny, nl, dc, dn, bm, ld, li, ly, sn);
    check("t2_landed", 32'(ld), 32'd0);
    check("t2_y",      32'(ly), 32'd0);

    // Right edge at 281 just overlaps the left end.
    run_scan(16'd265, 17'd40, 17'd30, -1, -1, -1, nx, ny, nl, dc, dn, bm, ld, li, ly, sn);
    check("t3_landed", 32'(ld), 32'd1);
    check("t3_y",      32'(ly), 32'd35);

    // Two candidates: the higher one wins.
    clear_tables();
    set_plat(3, 16'd100, 16'd250, 4'd5);
    set_plat(5, 16'd100, 16'd380, 4'd5);
    run_scan(16'd110, 17'd400, 17'd200, -1, -1, -1, nx, ny, nl, dc, dn, bm, ld, li, ly, sn);
    check("t4_idx", 32'(li), 32'd5);
    check("t4_y",   32'(ly), 32'd380);

    // Equal heights: the lower index wins.
    set_plat(5, 16'd100, 16'd250, 4'd5);
    run_scan(16'd110, 17'd400, 17'd200, -1, -1, -1, nx, ny, nl, dc, dn, bm, ld, li, ly, sn);
    check("t5_idx", 32'(li), 32'd3);
    check("t5_y",   32'(ly), 32'd250);

    // Rising sweep misses; a start in cycle 4 is ignored.
    clear_tables();
    set_plat(0, 16'd280, 16'd35, 4'd10);
    run_scan(16'd300, 17'd30, 17'd40, -1, 4, -1, nx, ny, nl, dc, dn, bm, ld, li, ly, sn);
    check("t6_landed",   32'(ld), 32'd0);
    check("t6_done_cyc", 32'(dc), 32'd8);
    check("t6_done_cnt", 32'(dn), 32'd1);

    // Block switch in cycle 3 to a table whose only platform is 2 (top 20).
    nx = '0; ny = '0; nl = '0;
    nx[2*16 +: 16] = 16'd280; ny[2*16 +: 16] = 16'd20; nl[2*4 +: 4] = 4'd10;
    run_scan(16'd300, 17'd40, 17'd10, 3, -1, -1, nx, ny, nl, dc, dn, bm, ld, li, ly, sn);
    check("t7_done_cyc",  32'(dc), 32'd11);
    check("t7_busy_mask", 32'(bm), 32'h07FE);
    check("t7_landed",    32'(ld), 32'd1);
    check("t7_idx",       32'(li), 32'd2);
    check("t7_y",         32'(ly), 32'd20);

    // Reset in cycle 5 aborts the scan and clears the held result.
    clear_tables();
    set_plat(0, 16'd280, 16'd35, 4'd10);
    run_scan(16'd300, 17'd40, 17'd30, -1, -1, 5, nx, ny, nl, dc, dn, bm, ld, li, ly, sn);
    check("t8_done_cnt", 32'(dn), 32'd0);
    check("t8_snap_c6",  32'(sn), 32'd0);

    // Exact touch without falling misses; one pixel of fall hits.
    run_scan(16'd300, 17'd35, 17'd35, -1, -1, -1, nx, ny, nl, dc, dn, bm, ld, li, ly, sn);
    check("t9_still_landed", 32'(ld), 32'd0);
    run_scan(16'd300, 17'd35, 17'd34, -1, -1, -1, nx, ny, nl, dc, dn, bm, ld, li, ly, sn);
    check("t9_fall_landed", 32'(ld), 32'd1);
    check("t9_fall_y",      32'(ly), 32'd35);

    // Falling below zero onto a ground-level platform needs signed compares.
    set_plat(0, 16'd280, 16'd0, 4'd10);
    run_scan(16'd300, 17'd5, -17'sd3, -1, -1, -1, nx, ny, nl, dc, dn, bm, ld, li, ly, sn);
    check("t10_neg_landed", 32'(ld), 32'd1);
    check("t10_neg_y",      32'(ly), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
